// File: rtl/retire_trace.sv
// retire_trace: records one entry per retired instruction, from up to LANES retire lanes, into a
// circular buffer. A reader drains the buffer through a valid/ready port.
// RING=0 keeps the oldest records when the buffer is full; RING=1 keeps the newest.
// Defining RETIRE_TRACE_TIMESTAMP_EN appends a 32-bit cycle stamp as the LSB field of each record.
module retire_trace #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned LANES = 1,
    parameter int unsigned RING  = 0,
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    localparam int unsigned REC_W = 4 + 3 * DW + 32,
`else
    localparam int unsigned REC_W = 4 + 3 * DW,
`endif
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES-1:0]      ret_valid,
    input  logic [4*LANES-1:0]    ret_kind,
    input  logic [DW*LANES-1:0]   ret_pc,
    input  logic [DW*LANES-1:0]   ret_addr,
    input  logic [DW*LANES-1:0]   ret_data,
    input  logic                  halt,
    input  logic                  clear,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [REC_W-1:0]      rd_rec,
    output logic [CW-1:0]         count,
    output logic [15:0]           dropped,
    output logic                  frozen
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q;
    logic [15:0]   dropped_q, dropped_d;
    logic          frozen_q, frozen_d;
    logic          pop;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [31:0]   ts_q;
`endif

    logic [LANES-1:0] we;
    logic [PW-1:0]    waddr [LANES];
    logic [REC_W-1:0] wrec  [LANES];

    int unsigned cnt, p, space, want, acc, excess, drops, drop_sum;

    // Next-state: lane acceptance, overwrite of oldest records in ring mode, pointer and count
    // bookkeeping. Clear overrides everything that happens in the same cycle.
    always_comb begin
        pop      = valid_q & rd_ready;
        cnt      = 32'(count_q);
        p        = 32'(pop);
        space    = DEPTH - cnt + p;
        want     = 0;
        acc      = 0;
        excess   = 0;
        we       = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            wrec[i]  = {ret_kind[4*i +: 4], ret_pc[DW*i +: DW], ret_addr[DW*i +: DW],
                        ret_data[DW*i +: DW]
`ifdef RETIRE_TRACE_TIMESTAMP_EN
                        , ts_q
`endif
                        };
            // Lanes pack densely: an accepted lane takes the next free slot.
            waddr[i] = wr_ptr_q + PW'(acc);
            if (ret_valid[i] && !frozen_q) begin
                want = want + 1;
                if (RING != 0 || acc < space) begin
                    we[i] = 1'b1;
                    acc   = acc + 1;
                end
            end
        end
        if (RING != 0 && cnt + want > DEPTH + p) begin
            excess = cnt + want - DEPTH - p;
        end
        drops     = (want - acc) + excess;
        drop_sum  = 32'(dropped_q) + drops;
        dropped_d = (drop_sum > 32'h0000_FFFF) ? 16'hFFFF : drop_sum[15:0];
        count_d   = CW'(cnt + acc - p - excess);
        rd_ptr_d  = rd_ptr_q + PW'(p) + PW'(excess);
        wr_ptr_d  = wr_ptr_q + PW'(acc);
        frozen_d  = frozen_q | halt;
        if (clear) begin
            we        = '0;
            count_d   = '0;
            dropped_d = '0;
            frozen_d  = 1'b0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            dropped_q <= '0;
            frozen_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            valid_q   <= (count_d != '0);
            dropped_q <= dropped_d;
            frozen_q  <= frozen_d;
        end
    end

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    // Free-running cycle stamp shared by all lanes in a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (clear) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end
`endif

    // Record storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (we[i]) begin
                mem[waddr[i]] <= wrec[i];
            end
        end
    end

    assign rd_rec   = mem[rd_ptr_q];
    assign rd_valid = valid_q;
    assign count    = count_q;
    assign dropped  = dropped_q;
    assign frozen   = frozen_q;

endmodule

// File: tb/tb_retire_trace.sv
// Bench for retire_trace: a stop-on-full two-lane instance and a ring one-lane instance, both
// DEPTH=4. Expected popped records go into per-instance queues; a negedge monitor compares them.
module tb_retire_trace;

    localparam int DW = 16;
    localparam int BW = 4 + 3 * DW;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    localparam int RW = BW + 32;
`else
    localparam int RW = BW;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Stop-on-full, two lanes
    logic [1:0]    s_valid;
    logic [7:0]    s_kind;
    logic [31:0]   s_pc, s_addr, s_data;
    logic          s_halt, s_clear, s_ready;
    logic          s_rd_valid;
    logic [RW-1:0] s_rec;
    logic [2:0]    s_count;
    logic [15:0]   s_dropped;
    logic          s_frozen;

    // Ring, one lane
    logic [0:0]    r_valid;
    logic [3:0]    r_kind;
    logic [15:0]   r_pc, r_addr, r_data;
    logic          r_ready;
    logic          r_rd_valid;
    logic [RW-1:0] r_rec;
    logic [2:0]    r_count;
    logic [15:0]   r_dropped;
    logic          r_frozen;

    retire_trace #(.DW(DW), .DEPTH(4), .LANES(2), .RING(0)) u_stop (
        .clk(clk), .rst_n(rst_n), .ret_valid(s_valid), .ret_kind(s_kind), .ret_pc(s_pc),
        .ret_addr(s_addr), .ret_data(s_data), .halt(s_halt), .clear(s_clear),
        .rd_valid(s_rd_valid), .rd_ready(s_ready), .rd_rec(s_rec), .count(s_count),
        .dropped(s_dropped), .frozen(s_frozen)
    );

    retire_trace #(.DW(DW), .DEPTH(4), .LANES(1), .RING(1)) u_ring (
        .clk(clk), .rst_n(rst_n), .ret_valid(r_valid), .ret_kind(r_kind), .ret_pc(r_pc),
        .ret_addr(r_addr), .ret_data(r_data), .halt(1'b0), .clear(1'b0),
        .rd_valid(r_rd_valid), .rd_ready(r_ready), .rd_rec(r_rec), .count(r_count),
        .dropped(r_dropped), .frozen(r_frozen)
    );

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] s_q[$];
    logic [BW-1:0] r_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input logic [3:0] k, input logic [15:0] pc,
                                         input logic [15:0] a, input logic [15:0] d);
        return {k, pc, a, d};
    endfunction

    function automatic logic [BW-1:0] rec_n(input int i);
        return mk(4'(i % 16), 16'(16'h0100 + i), 16'(i), 16'(16'hA000 + i));
    endfunction

    // Monitor: every accepted pop must match the oldest expected record.
    always @(negedge clk) begin
        if (rst_n && s_rd_valid && s_ready) begin
            if (s_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL stop_pop_unexpected: got %0h expected none", s_rec[RW-1 -: BW]);
            end else begin
                chk("stop_pop", 64'(s_rec[RW-1 -: BW]), 64'(s_q.pop_front()));
            end
        end
        if (rst_n && r_rd_valid && r_ready) begin
            if (r_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ring_pop_unexpected: got %0h expected none", r_rec[RW-1 -: BW]);
            end else begin
                chk("ring_pop", 64'(r_rec[RW-1 -: BW]), 64'(r_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_ret(input logic [1:0] v, input logic [BW-1:0] r0, input logic [BW-1:0] r1,
                         input logic h);
        s_valid = v;
        {s_kind[3:0], s_pc[15:0], s_addr[15:0], s_data[15:0]} = r0;
        {s_kind[7:4], s_pc[31:16], s_addr[31:16], s_data[31:16]} = r1;
        s_halt = h;
        tick();
        s_valid = '0;
        s_halt = 1'b0;
    endtask

    task automatic r_ret(input logic [BW-1:0] r);
        r_valid = 1'b1;
        {r_kind, r_pc, r_addr, r_data} = r;
        tick();
        r_valid = 1'b0;
    endtask

    task automatic s_drain();
        s_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!s_rd_valid) break;
        end
        s_ready = 1'b0;
        chk("stop_drain_done", 64'(s_rd_valid), 64'd0);
    endtask

    task automatic r_drain();
        r_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!r_rd_valid) break;
        end
        r_ready = 1'b0;
        chk("ring_drain_done", 64'(r_rd_valid), 64'd0);
    endtask

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [31:0] ts1, ts2;
`endif

    initial begin
        rst_n = 1'b0;
        s_valid = '0; s_kind = '0; s_pc = '0; s_addr = '0; s_data = '0;
        s_halt = 1'b0; s_clear = 1'b0; s_ready = 1'b0;
        r_valid = '0; r_kind = '0; r_pc = '0; r_addr = '0; r_data = '0; r_ready = 1'b0;
        #22;
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_count", 64'(s_count), 64'd0);
        chk("rst_valid", 64'(s_rd_valid), 64'd0);
        chk("rst_dropped", 64'(s_dropped), 64'd0);
        chk("rst_frozen", 64'(s_frozen), 64'd0);
        chk("rst_ring_count", 64'(r_count), 64'd0);
        chk("rst_ring_valid", 64'(r_rd_valid), 64'd0);

        // Single record, one-cycle latency, then pop
        s_ret(2'b01, mk(4'd0, 16'h0010, 16'h0003, 16'h1234), '0, 1'b0);
        chk("first_valid", 64'(s_rd_valid), 64'd1);
        chk("first_count", 64'(s_count), 64'd1);
        chk("first_rec", 64'(s_rec[RW-1 -: BW]), 64'(mk(4'd0, 16'h0010, 16'h0003, 16'h1234)));
        s_q.push_back(mk(4'd0, 16'h0010, 16'h0003, 16'h1234));
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        chk("pop_count", 64'(s_count), 64'd0);
        chk("pop_valid", 64'(s_rd_valid), 64'd0);

        // Stop-on-full: six retires keep the first four
        for (int i = 1; i <= 6; i++) s_ret(2'b01, rec_n(i), '0, 1'b0);
        chk("full_count", 64'(s_count), 64'd4);
        chk("full_dropped", 64'(s_dropped), 64'd2);
        for (int i = 1; i <= 4; i++) s_q.push_back(rec_n(i));
        s_drain();
        chk("full_drained", 64'(s_count), 64'd0);

        // Two lanes with one free slot: lane 0 stored, lane 1 dropped
        s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        chk("clear_dropped", 64'(s_dropped), 64'd0);
        for (int i = 1; i <= 3; i++) s_ret(2'b01, rec_n(i), '0, 1'b0);
        s_ret(2'b11, rec_n(7), rec_n(8), 1'b0);
        chk("dual_count", 64'(s_count), 64'd4);
        chk("dual_dropped", 64'(s_dropped), 64'd1);
        for (int i = 1; i <= 3; i++) s_q.push_back(rec_n(i));
        s_q.push_back(rec_n(7));
        s_drain();
        // Both lanes accepted, lane 0 first
        s_ret(2'b11, rec_n(9), rec_n(10), 1'b0);
        chk("dual_both_count", 64'(s_count), 64'd2);
        s_q.push_back(rec_n(9));
        s_q.push_back(rec_n(10));
        s_drain();
        // Lane 1 alone
        s_ret(2'b10, '0, rec_n(11), 1'b0);
        chk("lane1_count", 64'(s_count), 64'd1);
        s_q.push_back(rec_n(11));
        s_drain();

        // Halt: same-cycle record kept, later retires ignored and not counted
        s_ret(2'b01, rec_n(12), '0, 1'b1);
        chk("halt_frozen", 64'(s_frozen), 64'd1);
        chk("halt_count", 64'(s_count), 64'd1);
        s_ret(2'b11, rec_n(13), rec_n(14), 1'b0);
        s_ret(2'b01, rec_n(15), '0, 1'b0);
        chk("frozen_count", 64'(s_count), 64'd1);
        chk("frozen_dropped", 64'(s_dropped), 64'd1);
        s_q.push_back(rec_n(12));
        s_drain();
        chk("frozen_after_drain", 64'(s_frozen), 64'd1);
        // Clear wins over a same-cycle retire
        s_valid = 2'b01;
        s_clear = 1'b1;
        tick();
        s_valid = '0;
        s_clear = 1'b0;
        chk("clear_frozen", 64'(s_frozen), 64'd0);
        chk("clear_count", 64'(s_count), 64'd0);
        chk("clear_dropped2", 64'(s_dropped), 64'd0);
        s_ret(2'b01, rec_n(16), '0, 1'b0);
        chk("post_clear_count", 64'(s_count), 64'd1);
        s_q.push_back(rec_n(16));
        s_drain();

`ifdef RETIRE_TRACE_TIMESTAMP_EN
        // Retires four cycles apart carry stamps four apart
        s_ret(2'b01, rec_n(17), '0, 1'b0);
        tick(); tick(); tick();
        s_ret(2'b01, rec_n(18), '0, 1'b0);
        ts1 = s_rec[31:0];
        s_q.push_back(rec_n(17));
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        ts2 = s_rec[31:0];
        chk("ts_delta", 64'(ts2 - ts1), 64'd4);
        s_q.push_back(rec_n(18));
        s_drain();
`endif

        // Ring: six retires keep the last four
        for (int i = 1; i <= 6; i++) r_ret(rec_n(i));
        chk("ring_count", 64'(r_count), 64'd4);
        chk("ring_dropped", 64'(r_dropped), 64'd2);
        for (int i = 3; i <= 6; i++) r_q.push_back(rec_n(i));
        r_drain();
        chk("ring_drained", 64'(r_count), 64'd0);
        // Full, pop and overwrite in the same cycle: old head is popped
        for (int i = 7; i <= 10; i++) r_ret(rec_n(i));
        chk("ring_refill", 64'(r_count), 64'd4);
        r_q.push_back(rec_n(7));
        r_ready = 1'b1;
        r_ret(rec_n(11));
        r_ready = 1'b0;
        chk("ring_popwrite_count", 64'(r_count), 64'd4);
        chk("ring_popwrite_dropped", 64'(r_dropped), 64'd2);
        for (int i = 8; i <= 11; i++) r_q.push_back(rec_n(i));
        r_drain();

        chk("stop_queue_empty", 64'(s_q.size()), 64'd0);
        chk("ring_queue_empty", 64'(r_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/retire_trace.md
# retire_trace

Synthesizable retirement trace recorder for the pipelined CPU. It captures one record per retired instruction from up to two retire lanes into an on-chip circular buffer, and freezes on halt. The buffer is drained through a valid/ready port by a debug or host reader, which replaces simulation-only text logging in hardware builds. It sits beside the execute/writeback stage and observes retire signals only; it never back-pressures the core.

## Interface
- `DW`, 16, width of PC, address and data fields
- `DEPTH`, 64, buffer records; power of two, ≥2
- `LANES`, 1, retire lanes; 1 or 2
- `RING`, 0, 0 = stop-on-full (keep oldest), 1 = ring (keep newest)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ret_valid`  in  LANES  lane i retired an instruction this cycle
- `ret_kind`  in  4*LANES  0 sub, 1 movl, 2 movh, 3 ld, 4 st, 5 jz, 6 jnz, 7 js, 8 jns; 9–15 reserved, recorded as-is
- `ret_pc`  in  DW*LANES  PC of retired instruction
- `ret_addr`  in  DW*LANES  reg index (sub/movl/movh/ld), mem address (st), 0 (jumps)
- `ret_data`  in  DW*LANES  written reg data, stored mem data, or jump target
- `halt`  in  1  core halted; freezes capture
- `clear`  in  1  synchronous flush
- `rd_valid`  out  1  record available
- `rd_ready`  in  1  reader accepts
- `rd_rec`  out  REC_W  {kind, pc, addr, data}, kind in MSBs; REC_W = 4+3*DW (+32 with timestamp)
- `count`  out  $clog2(DEPTH+1)  records held
- `dropped`  out  16  records lost, saturates at 16'hFFFF
- `frozen`  out  1  capture stopped by halt

## Operation
- Per cycle: p = rd_valid & rd_ready (0/1). w = valid lanes while not frozen (0..LANES). Lane 0 is older than lane 1 and is written first.
- Stop-on-full (`RING`=0): accept min(w, DEPTH−count+p) lanes in lane order. Refused lanes increment `dropped`.
- Ring (`RING`=1): all w are written. excess = max(0, count−p+w−DEPTH) oldest records are discarded, and the read pointer advances by p+excess. `dropped` += excess. A pop and an overwrite in the same cycle are both honoured; the popped record is the one shown on `rd_rec` that cycle.
- `count` next = count − p + accepted − excess, never above DEPTH.
- `halt` sampled high: records presented that same cycle are captured, then `frozen`=1. Later retires are ignored and do not count as dropped. Draining continues while frozen.
- `clear`: pointers, `count`, `dropped`, `frozen` (and timestamp) return to reset values. Has priority over retire, halt and pop in that cycle. Records presented that cycle are discarded and not counted.
- Pointers wrap modulo DEPTH. `dropped` saturates and does not wrap.
- Reset: `rd_valid`=0, `count`=0, `dropped`=0, `frozen`=0, pointers 0, `rd_rec` = buffer content at read pointer (undefined after reset; don't-care while `rd_valid`=0).

## Timing
- Record retired at edge N is visible on `rd_rec` with `rd_valid`=1 from edge N+1 (1-cycle latency) when the buffer was empty.
- `rd_rec` is a combinational read of the registered read pointer. `rd_valid` = (count≠0), registered.
- `rd_rec` stays stable while `rd_valid`&!`rd_ready`, except in ring mode when an overwrite discards the head.
- `count`, `dropped`, `frozen` update at the same edge as the causing event.
- Asserting `rst_n` mid-operation clears all state immediately; no partial record survives.

## Configuration
- `RETIRE_TRACE_TIMESTAMP_EN` defined: a free-running 32-bit cycle counter (reset 0, cleared by `clear`, wraps) is appended as the LSB field of each record, REC_W = 4+3*DW+32. Both lanes in the same cycle get the same stamp.
- Undefined: no counter; REC_W = 4+3*DW.

## Test plan
- Reset, then one retire kind=0 pc=0010 addr=0003 data=1234 → next cycle `rd_valid`=1, `rd_rec`={0,0010,0003,1234}, `count`=1. Pop → `count`=0, `rd_valid`=0.
- RING=0, DEPTH=4, six single retires with no reads → `count`=4, `dropped`=2, drain yields records 1–4 in order.
- RING=1, DEPTH=4, six retires → drain yields records 3–6, `dropped`=2. Pop concurrent with overwrite when full → `count` stays 4 and the popped record is the old head.
- LANES=2, count=DEPTH−1, both lanes valid, RING=0 → lane 0 stored, lane 1 dropped, `dropped`=1.
- halt high with a retire the same cycle → that record stored, `frozen`=1. Further retires leave `count` and `dropped` unchanged. `clear` → `frozen`=0, `count`=0.
- With `RETIRE_TRACE_TIMESTAMP_EN`: retires at cycles 5 and 9 after reset → stamps differ by 4.
